// File: rtl/qei_decoder.sv
// qei_decoder: filtered x4 quadrature decoder with wrapped position and saturating per-period velocity.
// Optional QEI_INDEX_EN: a filtered rising edge on enc_z_i zeroes the position.
`ifndef PID_RES
`define PID_RES 16
`endif

module qei_decoder #(
    parameter int nbits      = `PID_RES,
    parameter int sample_div = 50000,
    parameter int filt_len   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             enc_a_i,
    input  logic             enc_b_i,
    input  logic             enc_z_i,
    output logic [nbits-1:0] pos_o,
    output logic [nbits-1:0] pv_o,
    output logic             pv_valid_o,
    output logic             err_o
);
    localparam int fw = $clog2(filt_len + 1);
    localparam int dw = $clog2(sample_div);
    localparam int pw = $clog2(filt_len + 4);
`ifdef QEI_INDEX_EN
    localparam int nch = 3;
    logic [nch-1:0] raw;
    assign raw = {enc_z_i, enc_a_i, enc_b_i};
`else
    localparam int nch = 2;
    logic [nch-1:0] raw;
    logic unused_z;
    assign raw = {enc_a_i, enc_b_i};
    assign unused_z = enc_z_i;
`endif
    logic [nch-1:0] s1, s2, filt;
    logic [1:0] prev, ip, ic, d;
    logic [pw-1:0] pcnt;
    logic [dw-1:0] div;
    logic [nbits-1:0] acc, sat;
    logic [nbits:0] stp, sum;
    logic primed, up, dn, bad, tick, zrise;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end

    for (genvar i = 0; i < nch; i++) begin : g_filt
        logic [fw-1:0] cnt;
        logic f;
        always_ff @(posedge clk or negedge rst)
            if (!rst) begin
                cnt <= '0;
                f <= 1'b0;
            end else if (s2[i] == f) cnt <= '0;
            else if (cnt == fw'(filt_len - 1)) begin
                cnt <= '0;
                f <= s2[i];
            end else cnt <= cnt + 1'b1;
        assign filt[i] = f;
    end

    // Gray index of {a,b}: 00,10,11,01 -> 0,1,2,3; the index difference gives the step
    assign ip = {prev[0], prev[1] ^ prev[0]};
    assign ic = {filt[0], filt[1] ^ filt[0]};
    assign d = ic - ip;
    assign up = primed && d == 2'd1;
    assign dn = primed && d == 2'd3;
    assign bad = primed && d == 2'd2;
    assign stp = up ? (nbits + 1)'(1) : dn ? '1 : '0;
    assign sum = {acc[nbits-1], acc} + stp;
    assign sat = (sum[nbits] == sum[nbits-1]) ? sum[nbits-1:0] : {sum[nbits], {(nbits - 1){~sum[nbits]}}};
    assign tick = en && div == dw'(sample_div - 1);

`ifdef QEI_INDEX_EN
    logic zprev;
    always_ff @(posedge clk or negedge rst)
        if (!rst) zprev <= 1'b0;
        else zprev <= filt[2];
    assign zrise = primed && filt[2] && !zprev;
`else
    assign zrise = 1'b0;
`endif

    // primed waits until the sync chain and filters have settled on the real input levels
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            prev <= '0;
            primed <= 1'b0;
            pcnt <= '0;
            pos_o <= '0;
            acc <= '0;
            div <= '0;
            pv_o <= '0;
            pv_valid_o <= 1'b0;
            err_o <= 1'b0;
        end else begin
            prev <= filt[1:0];
            if (!primed) begin
                pcnt <= pcnt + 1'b1;
                primed <= pcnt == pw'(filt_len + 2);
            end
            pv_valid_o <= tick && !clr;
            if (clr) begin
                pos_o <= '0;
                acc <= '0;
                div <= '0;
                pv_o <= '0;
                err_o <= 1'b0;
            end else if (en) begin
                pos_o <= zrise ? '0 : pos_o + stp[nbits-1:0];
                err_o <= err_o | bad;
                if (tick) begin
                    pv_o <= sat;
                    acc <= '0;
                    div <= '0;
                end else begin
                    acc <= sat;
                    div <= div + 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_qei_decoder.sv
// tb_qei_decoder: scoreboard bench for qei_decoder at nbits=16, sample_div=100, filt_len=3.
module tb_qei_decoder;
    typedef struct {
        int          due;
        logic [15:0] val;
    } pos_exp_t;

    logic clk = 1'b0, rst = 1'b0, clr = 1'b0, en = 1'b1;
    logic enc_a = 1'b1, enc_b = 1'b1, enc_z = 1'b0;
    logic [15:0] pos, pv;
    logic pv_valid, err;
    int cyc = 0, errors = 0, checks = 0;
    logic [15:0] mpos = '0;
    logic [1:0] ab = 2'b11;
    pos_exp_t pos_q[$];
    logic [15:0] pv_q[$];

    qei_decoder #(.nbits(16), .sample_div(100), .filt_len(3)) dut (
        .clk(clk), .rst(rst), .clr(clr), .en(en),
        .enc_a_i(enc_a), .enc_b_i(enc_b), .enc_z_i(enc_z),
        .pos_o(pos), .pv_o(pv), .pv_valid_o(pv_valid), .err_o(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: position entries fall due on a cycle, velocity entries on each pv_valid pulse
    always @(negedge clk) begin
        while (pos_q.size() > 0 && pos_q[0].due <= cyc) begin
            checks++;
            if (pos !== pos_q[0].val) begin
                errors++;
                $display("FAIL pos_sb cyc=%0d pos_o=%h expected=%h", cyc, pos, pos_q[0].val);
            end
            pos_q.delete(0);
        end
        if (pv_valid === 1'b1 && pv_q.size() > 0) begin
            checks++;
            if (pv !== pv_q[0]) begin
                errors++;
                $display("FAIL pv_sb cyc=%0d pv_o=%0d expected=%0d", cyc, $signed(pv), $signed(pv_q[0]));
            end
            pv_q.delete(0);
        end
    end

    task automatic mv(input bit fwd, input bit count, input int gap);
        pos_exp_t e;
        @(negedge clk);
        ab = fwd ? {~ab[0], ab[1]} : {ab[0], ~ab[1]};
        enc_a = ab[1];
        enc_b = ab[0];
        if (count) begin
            e.due = cyc + 5;
            e.val = mpos;
            pos_q.push_back(e);
            mpos = fwd ? mpos + 16'd1 : mpos - 16'd1;
            e.due = cyc + 6;
            e.val = mpos;
            pos_q.push_back(e);
        end
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 4;
        if (pos !== 16'd0) begin errors++; $display("FAIL rst_pos pos_o=%h expected=0000", pos); end
        if (pv !== 16'd0) begin errors++; $display("FAIL rst_pv pv_o=%h expected=0000", pv); end
        if (pv_valid !== 1'b0) begin errors++; $display("FAIL rst_valid pv_valid_o=%b expected=0", pv_valid); end
        if (err !== 1'b0) begin errors++; $display("FAIL rst_err err_o=%b expected=0", err); end
        rst = 1'b1;
        repeat (20) @(negedge clk);
        checks += 2;
        if (pos !== 16'd0) begin errors++; $display("FAIL prime_pos pos_o=%h expected=0000", pos); end
        if (err !== 1'b0) begin errors++; $display("FAIL prime_err err_o=%b expected=0", err); end
    endtask

    task automatic test_forward();
        repeat (8) mv(1'b1, 1'b1, 10);
        repeat (10) @(negedge clk);
        checks++;
        if (pos !== 16'd8) begin errors++; $display("FAIL fwd_pos pos_o=%h expected=0008", pos); end
    endtask

    task automatic test_reverse();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        mpos = 16'd0;
        checks++;
        if (pos !== 16'd0) begin errors++; $display("FAIL clr_pos pos_o=%h expected=0000", pos); end
        repeat (3) mv(1'b0, 1'b1, 10);
        repeat (5) @(negedge clk);
        checks += 2;
        if (pos !== 16'hFFFD) begin errors++; $display("FAIL rev_pos pos_o=%h expected=fffd", pos); end
        if (err !== 1'b0) begin errors++; $display("FAIL rev_err err_o=%b expected=0", err); end
    endtask

    task automatic test_velocity();
        int n = 0, t;
        int pc[$];
        while (pv_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (pv_valid !== 1'b1) begin
            errors++;
            $display("FAIL vel_sync pv_valid_o=%b after %0d cycles expected=1", pv_valid, n);
            return;
        end
        t = cyc;
        repeat (94) @(negedge clk);
        pv_q.push_back(16'd0);
        pv_q.push_back(16'd25);
        pv_q.push_back(16'd0);
        fork
            repeat (25) mv(1'b1, 1'b1, 4);
            repeat (210) begin
                @(negedge clk);
                if (pv_valid === 1'b1) pc.push_back(cyc);
            end
        join
        checks++;
        if (pc.size() != 3) begin
            errors++;
            $display("FAIL vel_pulses count=%0d expected=3", pc.size());
        end else begin
            checks += 3;
            if (pc[0] - t != 100) begin errors++; $display("FAIL vel_period0 gap=%0d expected=100", pc[0] - t); end
            if (pc[1] - pc[0] != 100) begin errors++; $display("FAIL vel_period1 gap=%0d expected=100", pc[1] - pc[0]); end
            if (pc[2] - pc[1] != 100) begin errors++; $display("FAIL vel_period2 gap=%0d expected=100", pc[2] - pc[1]); end
        end
        checks++;
        if (pv !== 16'd0) begin errors++; $display("FAIL vel_hold pv_o=%h expected=0000", pv); end
    endtask

    task automatic test_glitch_error();
        @(negedge clk);
        enc_a = ~ab[1];
        repeat (2) @(negedge clk);
        enc_a = ab[1];
        repeat (12) @(negedge clk);
        checks += 2;
        if (pos !== mpos) begin errors++; $display("FAIL glitch_pos pos_o=%h expected=%h", pos, mpos); end
        if (err !== 1'b0) begin errors++; $display("FAIL glitch_err err_o=%b expected=0", err); end
        @(negedge clk);
        ab = ~ab;
        enc_a = ab[1];
        enc_b = ab[0];
        repeat (10) @(negedge clk);
        checks += 2;
        if (err !== 1'b1) begin errors++; $display("FAIL dbl_err err_o=%b expected=1", err); end
        if (pos !== mpos) begin errors++; $display("FAIL dbl_pos pos_o=%h expected=%h", pos, mpos); end
        mv(1'b1, 1'b0, 1);
        repeat (5) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        mpos = 16'd0;
        checks += 2;
        if (pos !== 16'd0) begin errors++; $display("FAIL clr_step pos_o=%h expected=0000", pos); end
        if (err !== 1'b0) begin errors++; $display("FAIL clr_err err_o=%b expected=0", err); end
        repeat (10) @(negedge clk);
        checks++;
        if (pos !== 16'd0) begin errors++; $display("FAIL clr_after pos_o=%h expected=0000", pos); end
    endtask

    task automatic test_enable();
        int n = 0, seen = 0;
        while (pv_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (pv_valid !== 1'b1) begin
            errors++;
            $display("FAIL en_sync pv_valid_o=%b after %0d cycles expected=1", pv_valid, n);
            return;
        end
        repeat (40) @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ab = (i < 4) ? {~ab[0], ab[1]} : ~ab;
            enc_a = ab[1];
            enc_b = ab[0];
            repeat (10) begin
                @(negedge clk);
                if (pv_valid !== 1'b0) seen++;
            end
        end
        checks += 3;
        if (seen != 0) begin errors++; $display("FAIL en_valid pulses=%0d expected=0", seen); end
        if (pos !== mpos) begin errors++; $display("FAIL en_pos pos_o=%h expected=%h", pos, mpos); end
        if (err !== 1'b0) begin errors++; $display("FAIL en_err err_o=%b expected=0", err); end
        pv_q.push_back(16'd0);
        en = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (pv_valid !== 1'b1 && n < 150);
        checks += 2;
        if (n != 60) begin errors++; $display("FAIL en_resume cycles=%0d expected=60", n); end
        if (pos !== mpos) begin errors++; $display("FAIL en_reenable pos_o=%h expected=%h", pos, mpos); end
    endtask

    task automatic test_index();
        logic [15:0] exp_z;
`ifdef QEI_INDEX_EN
        exp_z = 16'd0;
`else
        exp_z = 16'd37;
`endif
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        mpos = 16'd0;
        repeat (37) mv(1'b1, 1'b1, 4);
        repeat (8) @(negedge clk);
        checks++;
        if (pos !== 16'd37) begin errors++; $display("FAIL idx_pre pos_o=%h expected=0025", pos); end
        @(negedge clk);
        enc_z = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (pos !== 16'd37) begin errors++; $display("FAIL idx_early pos_o=%h expected=0025", pos); end
        @(negedge clk);
        enc_z = 1'b0;
        checks++;
        if (pos !== exp_z) begin errors++; $display("FAIL idx_rise pos_o=%h expected=%h", pos, exp_z); end
        mpos = exp_z;
        repeat (10) @(negedge clk);
        checks++;
        if (pos !== exp_z) begin errors++; $display("FAIL idx_after pos_o=%h expected=%h", pos, exp_z); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_velocity();
        test_glitch_error();
        test_enable();
        test_index();
        checks += 2;
        if (pos_q.size() != 0) begin errors++; $display("FAIL pos_sb_left entries=%0d expected=0", pos_q.size()); end
        if (pv_q.size() != 0) begin errors++; $display("FAIL pv_sb_left entries=%0d expected=0", pv_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog sim_time=%0t limit=500000", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
